// File: rtl/dunc16_boot_loader.sv
// dunc16 boot loader: receives a length-prefixed big-endian byte image, writes it to program memory, then releases the CPU.
// Optional trailing 16-bit checksum is compiled in by defining DUNC16_BOOT_CHECKSUM_EN.
module dunc16_boot_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX_VALID,
  input  logic [7:0]        RX_DATA,
  output logic              RX_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DATA,
  output logic              CPU_RESET,
  output logic              DONE,
  output logic              ERROR
);

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
`ifdef DUNC16_BOOT_CHECKSUM_EN
    ST_CSUM_HI = 3'd4,
    ST_CSUM_LO = 3'd5,
`endif
    ST_RUN     = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Where the frame goes once the data words (possibly none) are in.
`ifdef DUNC16_BOOT_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM_HI;
`else
  localparam state_t ST_AFTER_DATA = ST_RUN;
`endif

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_data_q, mem_data_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef DUNC16_BOOT_CHECKSUM_EN
  logic [15:0]         sum_q, sum_d;
`endif

  logic                accept_s;
  logic [15:0]         rx_word_s;
  logic                last_word_s;

  assign accept_s    = RX_VALID & rx_ready_q;
  assign rx_word_s   = {byte_q, RX_DATA};
  assign last_word_s = ({1'b0, len_q} == ({{(17-ADDR_W){1'b0}}, idx_q} + 17'd1));

  // Next-state, write strobe and status decode.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    len_d      = len_q;
    idx_d      = idx_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef DUNC16_BOOT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (accept_s) begin
      case (state_q)
        ST_LEN_HI: begin
          byte_d  = RX_DATA;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d = rx_word_s;
          idx_d = '0;
`ifdef DUNC16_BOOT_CHECKSUM_EN
          sum_d = rx_word_s;
`endif
          if ({1'b0, rx_word_s} > CAPACITY) begin
            state_d = ST_ERR;
          end else if (rx_word_s == 16'd0) begin
            state_d = ST_AFTER_DATA;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          byte_d  = RX_DATA;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          mem_we_d   = 1'b1;
          mem_addr_d = idx_q;
          mem_data_d = rx_word_s;
          idx_d      = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef DUNC16_BOOT_CHECKSUM_EN
          sum_d      = sum_q + rx_word_s;
`endif
          if (last_word_s) begin
            state_d = ST_AFTER_DATA;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
`ifdef DUNC16_BOOT_CHECKSUM_EN
        ST_CSUM_HI: begin
          byte_d  = RX_DATA;
          state_d = ST_CSUM_LO;
        end
        ST_CSUM_LO: begin
          if (rx_word_s == sum_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
    // CPU release lags RUN entry by one edge so the final write has retired.
    rx_ready_d  = (state_d != ST_RUN) && (state_d != ST_ERR);
    cpu_reset_d = (state_q != ST_RUN);
    done_d      = (state_q == ST_RUN);
    error_d     = (state_d == ST_ERR);
  end

  // State and registered output update.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_LEN_HI;
      byte_q      <= 8'd0;
      len_q       <= 16'd0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 16'd0;
      rx_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef DUNC16_BOOT_CHECKSUM_EN
      sum_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef DUNC16_BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign RX_READY  = rx_ready_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DATA  = mem_data_q;
  assign CPU_RESET = cpu_reset_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;

endmodule
